// File: rtl/dijkstra_ci_controller.sv
// Nios II multi-cycle custom-instruction front end for the Dijkstra core.
// Decodes CONFIG/QUERY/STATUS/LAST_RESULT and sequences core reset, run and timeout.
module dijkstra_ci_controller #(
    parameter int INDEX_WIDTH    = 10,
    parameter int MAX_NODES      = 1024,
    parameter int VALUE_WIDTH    = 32,
    parameter int MADDR_WIDTH    = 32,
    parameter int DIV_RATIO      = 4,
    parameter int TIMEOUT_CYCLES = 16777215
) (
    input  logic                   algorithm_clock,
    input  logic                   algorithm_reset,
    input  logic                   ci_clk_en,
    input  logic                   ci_start,
    input  logic [1:0]             ci_n,
    input  logic [31:0]            ci_dataa,
    input  logic [31:0]            ci_datab,
    output logic                   ci_done,
    output logic [31:0]            ci_result,
    output logic                   core_tick,
    output logic                   core_reset,
    output logic [MADDR_WIDTH-1:0] core_base_address,
    output logic [INDEX_WIDTH-1:0] core_source,
    output logic [INDEX_WIDTH-1:0] core_destination,
    output logic [INDEX_WIDTH-1:0] core_num_nodes,
    input  logic                   core_ready,
    input  logic [VALUE_WIDTH-1:0] core_distance
);

    localparam int DW = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATIO - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RESP, S_CORE_RST, S_RUN, S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0]          tick_cnt, tick_cnt_nxt;
    logic [DW-1:0]          rst_cnt;
    logic [TW-1:0]          tmo_cnt;
    logic                   run_armed;
    logic                   configured;
    logic                   timeout_flag;
    logic [31:0]            last_result;
    logic [31:0]            resp_q;
    logic                   accept;
    logic                   query_ok;
    logic                   cfg_ok;
    logic                   num_in_range;
    logic                   rst_last;
    logic                   ready_hit;
    logic                   tmo_hit;
    logic [INDEX_WIDTH-1:0] num_in, src_in, dst_in;
    logic                   unused_bits;

    assign unused_bits = ^{ci_dataa, ci_datab};

    assign num_in = ci_datab[INDEX_WIDTH-1:0];
    assign src_in = ci_datab[INDEX_WIDTH-1:0];
    assign dst_in = ci_datab[2*INDEX_WIDTH-1:INDEX_WIDTH];

    // Skip the range compare when every encodable count is legal.
    if (MAX_NODES >= (1 << INDEX_WIDTH)) begin : g_cap_full
        assign num_in_range = 1'b1;
    end else begin : g_cap_part
        assign num_in_range = (num_in <= INDEX_WIDTH'(MAX_NODES));
    end

    assign cfg_ok    = (num_in != '0) && num_in_range;
    assign query_ok  = configured && (src_in < core_num_nodes)
                       && (dst_in < core_num_nodes);
    assign accept    = ci_start & ci_clk_en;
    assign rst_last  = (rst_cnt == DIV_LAST);
    assign ready_hit = core_tick & run_armed & core_ready;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    assign tick_cnt_nxt = (tick_cnt == DIV_LAST) ? '0 : tick_cnt + DW'(1);

    // core_tick is registered so it stays low while reset is held.
    always_ff @(posedge algorithm_clock or posedge algorithm_reset) begin
        if (algorithm_reset) begin
            tick_cnt  <= '0;
            core_tick <= 1'b0;
        end else begin
            tick_cnt  <= tick_cnt_nxt;
            core_tick <= (tick_cnt_nxt == DIV_LAST);
        end
    end

    always_ff @(posedge algorithm_clock or posedge algorithm_reset) begin
        if (algorithm_reset) state <= S_IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (ci_n == 2'd1 && query_ok) state_nxt = S_CORE_RST;
                    else                         state_nxt = S_RESP;
                end
            end
            S_RESP:     state_nxt = S_IDLE;
            S_CORE_RST: if (rst_last) state_nxt = S_RUN;
            S_RUN:      if (ready_hit || tmo_hit) state_nxt = S_FINISH;
            S_FINISH:   state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ci_done   = 1'b0;
        ci_result = '0;
        unique case (1'b1)
            (state == S_RESP): begin
                ci_done   = 1'b1;
                ci_result = resp_q;
            end
            (state == S_FINISH): begin
                ci_done   = 1'b1;
                ci_result = last_result;
            end
            default: ;
        endcase
    end

    always_ff @(posedge algorithm_clock or posedge algorithm_reset) begin
        if (algorithm_reset) begin
            core_reset        <= 1'b1;
            core_base_address <= '0;
            core_source       <= '0;
            core_destination  <= '0;
            core_num_nodes    <= '0;
            configured        <= 1'b0;
            timeout_flag      <= 1'b0;
            last_result       <= '0;
            resp_q            <= '0;
            rst_cnt           <= '0;
            tmo_cnt           <= '0;
            run_armed         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (ci_n)
                            2'd0: begin
                                core_base_address <= ci_dataa[MADDR_WIDTH-1:0];
                                core_num_nodes    <= num_in;
                                configured        <= cfg_ok;
                                resp_q            <= cfg_ok ? 32'h0 : 32'hFFFF_FFFF;
                            end
                            2'd1: begin
                                if (query_ok) begin
                                    core_source      <= src_in;
                                    core_destination <= dst_in;
                                    timeout_flag     <= 1'b0;
                                    core_reset       <= 1'b1;
                                    rst_cnt          <= '0;
                                end else begin
                                    resp_q <= 32'hFFFF_FFFF;
                                end
                            end
                            2'd2: resp_q <= {29'b0, core_ready, timeout_flag, configured};
                            default: resp_q <= last_result;
                        endcase
                    end
                end
                S_CORE_RST: begin
                    if (rst_last) begin
                        core_reset <= 1'b0;
                        tmo_cnt    <= '0;
                        run_armed  <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + DW'(1);
                    end
                end
                S_RUN: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    // First tick after restart may still carry the old ready.
                    if (core_tick) run_armed <= 1'b1;
                    if (ready_hit) begin
                        last_result <= 32'(core_distance);
                    end else if (tmo_hit) begin
                        timeout_flag <= 1'b1;
                        last_result  <= 32'hFFFF_FFFF;
                        core_reset   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dijkstra_ci_controller.sv
// Directed bench for dijkstra_ci_controller.
// Main instance uses a short timeout; a second instance checks DIV_RATIO=1.
module tb_dijkstra_ci_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        ci_clk_en, ci_start;
    logic [1:0]  ci_n;
    logic [31:0] ci_dataa, ci_datab;
    logic        ci_done;
    logic [31:0] ci_result;
    logic        core_tick, core_reset;
    logic [31:0] core_base_address;
    logic [9:0]  core_source, core_destination, core_num_nodes;
    logic        core_ready;
    logic [31:0] core_distance;

    logic        ci_done_d1;
    logic [31:0] ci_result_d1;
    logic        core_tick_d1, core_reset_d1;
    logic [31:0] base_d1;
    logic [9:0]  src_d1, dst_d1, num_d1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dijkstra_ci_controller #(
        .DIV_RATIO(4), .TIMEOUT_CYCLES(100)
    ) dut (
        .algorithm_clock(clk), .algorithm_reset(rst),
        .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_n(ci_n),
        .ci_dataa(ci_dataa), .ci_datab(ci_datab),
        .ci_done(ci_done), .ci_result(ci_result),
        .core_tick(core_tick), .core_reset(core_reset),
        .core_base_address(core_base_address),
        .core_source(core_source), .core_destination(core_destination),
        .core_num_nodes(core_num_nodes),
        .core_ready(core_ready), .core_distance(core_distance)
    );

    dijkstra_ci_controller #(
        .DIV_RATIO(1)
    ) dut1 (
        .algorithm_clock(clk), .algorithm_reset(rst),
        .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_n(ci_n),
        .ci_dataa(ci_dataa), .ci_datab(ci_datab),
        .ci_done(ci_done_d1), .ci_result(ci_result_d1),
        .core_tick(core_tick_d1), .core_reset(core_reset_d1),
        .core_base_address(base_d1),
        .core_source(src_d1), .core_destination(dst_d1),
        .core_num_nodes(num_d1),
        .core_ready(core_ready), .core_distance(core_distance)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue at a negedge; returns {done,result} seen one cycle later.
    task automatic op(input string tag, input logic [1:0] n,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
        ci_n = n; ci_dataa = a; ci_datab = b;
        ci_start = 1'b1; ci_clk_en = 1'b1;
        @(negedge clk);
        ci_start = 1'b0; ci_clk_en = 1'b0;
        chk(tag, {31'b0, ci_done, ci_result}, {32'h1, exp});
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] tv, tv1;
        logic [31:0] res;
        int hi, ticks, dones, lat, ones;

        rst = 1'b1; ci_clk_en = 1'b0; ci_start = 1'b0; ci_n = 2'd0;
        ci_dataa = '0; ci_datab = '0; core_ready = 1'b0; core_distance = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {ci_done, core_reset, core_tick, core_tick_d1, ci_result},
            {4'b0100, 32'h0});
        chk("rst_cfg", {core_base_address, 2'b0, core_num_nodes, 2'b0, core_source, core_destination},
            64'h0);
        rst = 1'b0;

        tv = '0; tv1 = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            tv[n]  = core_tick;
            tv1[n] = core_tick_d1;
        end
        chk("tick_div4", {48'b0, tv}, 64'h0888);
        chk("tick_div1", {48'b0, tv1}, 64'h1FFE);

        op("status_rst", 2'd2, 32'h0, 32'h0, 32'h0);
        chk("done_drop", {ci_done, ci_result, core_reset}, {1'b0, 32'h0, 1'b1});

        op("cfg_ok", 2'd0, 32'h1000, 32'd8, 32'h0);
        chk("cfg_regs", {core_base_address, 22'b0, core_num_nodes}, {32'h1000, 32'd8});
        op("status_cfg", 2'd2, 32'h0, 32'h0, 32'h1);
        op("cfg_zero", 2'd0, 32'h2000, 32'd0, 32'hFFFF_FFFF);
        op("status_uncfg", 2'd2, 32'h0, 32'h0, 32'h0);
        op("cfg_again", 2'd0, 32'h1000, 32'd8, 32'h0);

        // Start without the clock enable must be dropped.
        ci_n = 2'd2; ci_start = 1'b1; ci_clk_en = 1'b0;
        @(negedge clk);
        ci_start = 1'b0;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (ci_done) dones++;
            @(negedge clk);
        end
        chk("no_clk_en", 64'(dones), 64'd0);

        op("qry_bad_dst", 2'd1, 32'h0, (32'd9 << 10) | 32'd2, 32'hFFFF_FFFF);
        chk("qry_bad_core", {core_reset, 22'b0, core_source}, {1'b1, 32'h0});

        ci_n = 2'd1; ci_datab = (32'd5 << 10) | 32'd2;
        ci_start = 1'b1; ci_clk_en = 1'b1;
        @(negedge clk);
        ci_start = 1'b0; ci_clk_en = 1'b0;
        chk("qry_no_resp", {63'b0, ci_done}, 64'd0);
        hi = 0;
        while (core_reset && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        chk("rst_len", 64'(hi), 64'd4);
        chk("src_dst", {44'b0, core_source, core_destination}, {44'b0, 10'd2, 10'd5});

        ticks = 0; dones = 0; res = '0;
        for (int i = 0; i < 40; i++) begin
            if (ci_done) begin
                dones++;
                res = ci_result;
            end
            ci_start = 1'b0; ci_clk_en = 1'b0; core_ready = 1'b0;
            if (core_tick) begin
                ticks++;
                if (ticks == 1) begin core_ready = 1'b1; core_distance = 32'd99; end
                if (ticks == 2) begin ci_start = 1'b1; ci_clk_en = 1'b1; ci_n = 2'd2; end
                if (ticks == 3) begin core_ready = 1'b1; core_distance = 32'd37; end
            end
            @(negedge clk);
        end
        core_ready = 1'b0; ci_start = 1'b0; ci_clk_en = 1'b0;
        chk("run_dones", 64'(dones), 64'd1);
        chk("run_result", {32'b0, res}, 64'd37);
        chk("run_core_rst", {63'b0, core_reset}, 64'd0);
        op("last_37", 2'd3, 32'h0, 32'h0, 32'd37);
        op("status_run", 2'd2, 32'h0, 32'h0, 32'h1);

        ci_n = 2'd1; ci_datab = (32'd3 << 10) | 32'd1;
        ci_start = 1'b1; ci_clk_en = 1'b1;
        @(negedge clk);
        ci_start = 1'b0; ci_clk_en = 1'b0;
        lat = 1;
        while (!ci_done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("tmo_lat", {63'b0, (lat >= 100 && lat <= 110)}, 64'd1);
        chk("tmo_result", {31'b0, ci_done, ci_result}, {32'h1, 32'hFFFF_FFFF});
        @(negedge clk);
        chk("tmo_core_rst", {63'b0, core_reset}, 64'd1);
        op("status_tmo", 2'd2, 32'h0, 32'h0, 32'h3);
        op("last_tmo", 2'd3, 32'h0, 32'h0, 32'hFFFF_FFFF);

        ci_n = 2'd1; ci_datab = (32'd4 << 10) | 32'd0;
        ci_start = 1'b1; ci_clk_en = 1'b1;
        @(negedge clk);
        ci_start = 1'b0; ci_clk_en = 1'b0;
        hi = 0;
        while (core_reset && hi < 20) begin
            hi++;
            @(negedge clk);
        end
        chk("mid_reach_run", {63'b0, core_reset}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {ci_done, core_reset, core_tick, ci_result}, {3'b010, 32'h0});
        chk("mid_rst_cfg", {core_base_address, 2'b0, core_num_nodes, 2'b0, core_source, core_destination},
            64'h0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0; ones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ci_done) dones++;
            if (core_tick_d1) ones++;
        end
        chk("mid_no_done", 64'(dones), 64'd0);
        chk("div1_const", 64'(ones), 64'd20);
        op("status_post", 2'd2, 32'h0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
